// File: rtl/nibble_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_sub
// Purpose  : W-bit (W = 4*NIBBLES) two's-complement add/subtract computed one
//            4-bit slice per clock, least-significant nibble first, with the
//            slice carry registered between steps. start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_sub #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   M,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   S,
  output logic                   C_final,
  output logic                   V
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            m_q;
  logic            carry;
  logic [CW-1:0]   step;
  logic [W-1:0]    acc;

  logic            accept;
  logic            last_step;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      low;
  logic [1:0]      high;
  logic [3:0]      sum_nib;
  logic            c_into3;
  logic            c_out;
  logic [W-1:0]    acc_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, return to IDLE after the last nibble
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (step == LAST) begin
          last_step  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slice: select nibble `step`, invert B in subtract mode, add with carry;
  // the low 3 bits are summed separately to expose the carry into bit 3
  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (step == CW'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4] ^ {4{m_q}};
      end
    end
    low      = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
    c_into3  = low[3];
    high     = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, c_into3};
    c_out    = high[1];
    sum_nib  = {high[0], low[2:0]};
    acc_next = acc;
    for (int n = 0; n < NIBBLES; n++) begin
      if (step == CW'(n)) begin
        acc_next[4*n +: 4] = sum_nib;
      end
    end
  end

  // Datapath: latch operands on accept, step one nibble per RUN cycle,
  // publish the full result only on the completing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      carry   <= 1'b0;
      step    <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      C_final <= 1'b0;
      V       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        m_q   <= M;
        carry <= M;
        step  <= '0;
        acc   <= '0;
        busy  <= 1'b1;
      end else if (state == RUN) begin
        acc   <= acc_next;
        carry <= c_out;
        step  <= step + 1'b1;
        if (last_step) begin
          S       <= acc_next;
          C_final <= c_out;
          V       <= c_into3 ^ c_out;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_add_sub
// Purpose  : Scoreboard bench for nibble_serial_add_sub (NIBBLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_sub;

  localparam int N    = 4;
  localparam int W    = 4 * N;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          M = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  S;
  logic          C_final;
  logic          V;

  nibble_serial_add_sub #(.NIBBLES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .M       (M),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .S       (S),
    .C_final (C_final),
    .V       (V)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc_edge;
  } exp_t;

  exp_t sbq[$];
  bit   busy_exp[0:MAXC-1];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: true signed/unsigned arithmetic on wide integers
  function automatic exp_t model(bit m, logic [W-1:0] a, logic [W-1:0] b, int e);
    exp_t   r;
    longint sa, sb, ua, ub, res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    res = m ? (sa - sb) : (sa + sb);
    r.s = res[W-1:0];
    r.v = (res > 32767) || (res < -32768);
    r.c = m ? (ua >= ub) : ((ua + ub) >= 65536);
    r.acc_edge = e;
    return r;
  endfunction

  // One cycle of stimulus, applied just after a rising edge
  task automatic drive(bit s, bit m, logic [W-1:0] a, logic [W-1:0] b);
    int e;
    @(posedge clk);
    #1;
    start = s;
    M     = m;
    A     = a;
    B     = b;
    if (s && rst_n && !busy_exp[cyc] && (cyc + N + 1 < MAXC)) begin
      e = cyc + 1;
      sbq.push_back(model(m, a, b, e));
      for (int k = 0; k < N; k++) busy_exp[e + k] = 1'b1;
    end
  endtask

  // One operation: request for a cycle, then N cycles of scrambled inputs
  // (start held high when `hold` is set, otherwise random)
  task automatic op(bit m, logic [W-1:0] a, logic [W-1:0] b, bit hold);
    drive(1'b1, m, a, b);
    for (int k = 0; k < N; k++)
      drive(hold ? 1'b1 : 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic check_reset_outputs(string tag);
    n_cmp += 4;
    if (busy !== 1'b0)    begin n_bad++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
    if (S !== '0)         begin n_bad++; $display("FAIL %s_S: got %h want 0000", tag, S); end
    if (C_final !== 1'b0) begin n_bad++; $display("FAIL %s_C: got %b want 0", tag, C_final); end
    if (V !== 1'b0)       begin n_bad++; $display("FAIL %s_V: got %b want 0", tag, V); end
  endtask

  // Monitor: check busy, done pulse shape, result hold and scoreboard
  logic [W-1:0] prev_s = '0;
  logic         prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      prev_s    = '0;
      prev_done = 1'b0;
    end else begin
      n_cmp++;
      if (busy !== busy_exp[cyc]) begin
        n_bad++;
        $display("FAIL busy@%0d: got %b want %b", cyc, busy, busy_exp[cyc]);
      end
      if (done === 1'b1) begin
        n_cmp++;
        if (prev_done) begin
          n_bad++;
          $display("FAIL done_width@%0d: got 2 consecutive cycles want 1", cyc);
        end
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done@%0d: got done want none", cyc);
        end else begin
          x = sbq.pop_front();
          n_cmp++;
          if (cyc != x.acc_edge + N) begin
            n_bad++;
            $display("FAIL latency: got edge %0d want %0d", cyc, x.acc_edge + N);
          end
          if ({S, C_final, V} !== {x.s, x.c, x.v}) begin
            n_bad++;
            $display("FAIL result@%0d: got S=%h C=%b V=%b want S=%h C=%b V=%b",
                     cyc, S, C_final, V, x.s, x.c, x.v);
          end
        end
      end else begin
        n_cmp++;
        if (S !== prev_s) begin
          n_bad++;
          $display("FAIL s_hold@%0d: got %h want %h", cyc, S, prev_s);
        end
      end
      prev_s    = S;
      prev_done = done;
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: add, back-to-back in the done cycle, subtract, overflow
    op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    op(1'b0, 16'h0003, 16'h0004, 1'b0);
    idle(2);
    op(1'b1, 16'h0001, 16'h0002, 1'b0);
    op(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    op(1'b1, 16'h8000, 16'h0001, 1'b0);
    idle(1);
    // start held high with new operands during RUN
    op(1'b0, 16'h4321, 16'h1111, 1'b1);
    idle(3);

    // Reset during RUN step 2: no done, outputs cleared at once
    drive(1'b1, 1'b0, 16'hABCD, 16'h1357);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    start = 1'b0;
    sbq.delete();
    for (int k = cyc; k < cyc + N + 4 && k < MAXC; k++) busy_exp[k] = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op(1'b0, 16'h00FF, 16'h0001, 1'b0);
    idle(2);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      op(1'($urandom), pick(), pick(), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // Drain, then require an empty scoreboard
    idle(N + 3);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL pending: got %0d outstanding results want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_add_sub.md
# nibble_serial_add_sub

Multi-cycle sequencer that performs W-bit two's-complement addition or subtraction (W = 4·NIBBLES) by driving one internal 4-bit add/sub slice, least-significant nibble first, one nibble per clock, with the carry registered between steps. It sits between a requesting controller and the result consumer. It reuses the team's 4-bit add/sub mode convention, extended with a registered carry-in so slices chain: M=0 adds; M=1 computes A + ~B + 1. A start/busy/done handshake brackets each operation.

## Interface
- NIBBLES, default 4: number of 4-bit steps; operand width W = 4·NIBBLES; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only while busy=0.
- M  input  1  mode: 0 = add, 1 = subtract; latched with operands.
- A  input  W  operand A, latched on the accepting edge.
- B  input  W  operand B, latched on the accepting edge.
- busy  output  1  high from the accepting edge until the completing edge.
- done  output  1  one-cycle pulse; S, C_final and V are valid from this cycle on.
- S  output  W  sum/difference, held until the next completion.
- C_final  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- V  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE and RUN. The internal step counter is ceil(log2(NIBBLES+1)) bits wide.
- IDLE, start=1:
  - latch A, B and M;
  - set carry register = M;
  - clear step counter i and accumulator;
  - busy<=1; go to RUN.
- IDLE, start=0: no change.
- RUN, step i on each edge:
  - slice inputs: A[4i+3:4i], B[4i+3:4i] XOR {4{M}}, and the carry register;
  - write the 4-bit slice sum into accumulator nibble i;
  - carry register <= slice carry out; i <= i+1.
- Last step (i = NIBBLES-1), on the same edge:
  - S <= full accumulator including the final nibble;
  - C_final <= slice carry out;
  - V <= carry into slice bit 3 XOR slice carry out;
  - done<=1; busy<=0; state -> IDLE.
- start while busy=1 is ignored. It is neither queued nor does it corrupt the latched operands.
- Changes to A, B or M after the accepting edge do not affect the running operation.
- S, C_final and V change only on completing edges. Partial nibbles are never visible at S.
- Arithmetic is modulo 2^W. Example: 0x0001 − 0x0002 = 0xFFFF with C_final=0.

## Timing
- Reset (async assert, any state): state=IDLE; busy=0, done=0, S=0, C_final=0, V=0; counter, carry and accumulator cleared.
  - Takes effect immediately, mid-operation included.
  - An aborted operation produces no done and no partial result.
- Latency: start accepted on edge k -> completing edge k+NIBBLES.
  - done=1 during the cycle after edge k+NIBBLES; busy high for exactly NIBBLES cycles.
- done is high for exactly one cycle per operation.
- Back-to-back operation: start=1 in the done cycle is accepted, because busy=0 there.
  - Throughput is one operation per NIBBLES cycles, with no bubble.
- NIBBLES=1: single-step operation. done follows the accepting edge by one edge.
- Deassertion of rst_n is assumed synchronized externally. The first start is sampled on the first edge after deassertion.

## Test plan
All scenarios use NIBBLES=4.
- Add: A=0x1234, B=0x0FFF, M=0, start pulsed at edge k -> done at k+4; S=0x2233, C_final=0, V=0; busy high for 4 cycles.
- Subtract with borrow: A=0x0001, B=0x0002, M=1 -> S=0xFFFF, C_final=0, V=0. Then A=0xFFFF, B=0x0001, M=1 -> S=0xFFFE, C_final=1, V=0.
- Overflow and full-length carry ripple:
  - 0x7FFF+0x0001 -> S=0x8000, C_final=0, V=1;
  - 0xFFFF+0x0001 -> S=0x0000, C_final=1, V=0;
  - 0x8000−0x0001 (M=1) -> S=0x7FFF, C_final=1, V=1.
- Handshake:
  - start held high with new operands during RUN is ignored; the result matches the first operands;
  - start=1 in the done cycle with 0x0003+0x0004 -> a second done exactly 4 cycles later with S=0x0007;
  - done is never high for 2 consecutive cycles.
- Operand stability: change A, B and M on every cycle of RUN -> the result equals the operation on the values latched at acceptance.
- Reset mid-operation: rst_n low during RUN step 2 -> busy=0, S=0, C_final=0, V=0 immediately, and no done. After release, 0x00FF+0x0001 -> S=0x0100 at the expected latency.
